// File: rtl/seg_digit_mux.sv
// Two-digit seven-segment multiplexer.
// Alternates two hex digits onto one shared decoder input and drives two
// active-low digit enables. A dark (blanking) phase separates every digit
// switch so the decoder input settles before the next digit lights. Both
// digits are captured once per frame, on entry to BLANK1, so a frame never
// shows a mix of old and new values.
module seg_digit_mux #(
   parameter int DWELL_CYCLES = 40,  // cycles each digit is lit (>=1)
   parameter int BLANK_CYCLES = 2    // dark cycles between digits (>=1)
) (
   input  logic       clk,
   input  logic       reset,       // synchronous, active-low
   input  logic [3:0] digit0_in,
   input  logic [3:0] digit1_in,
   output logic [3:0] nibble,
   output logic [1:0] an,
   output logic       frame_tick
);

   // The counter only has to reach the longer phase length minus one.
   // Keep at least one bit so the 1/1 configuration still elaborates.
   localparam int MAXLEN = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CW     = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

   typedef enum logic [1:0] {
      BLANK1 = 2'd0,
      DIG0   = 2'd1,
      BLANK0 = 2'd2,
      DIG1   = 2'd3
   } state_t;

   state_t          state_reg, state_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic [3:0]      l0_reg, l0_next;
   logic [3:0]      l1_reg, l1_next;
   logic [3:0]      nibble_reg, nibble_next;
   logic [1:0]      an_reg, an_next;
   logic            frame_tick_reg, frame_tick_next;

   logic [CW-1:0]   len_last;
   logic            last;
   logic            enter_blank1;
   logic            enter_blank0;
   logic            enter_dig0;

   // Next-state, phase counter, digit latches and registered output values.
   always_comb begin
      len_last        = BLANK_LAST;
      state_next      = state_reg;
      cnt_next        = cnt_reg + 1'b1;
      enter_blank1    = 1'b0;
      enter_blank0    = 1'b0;
      enter_dig0      = 1'b0;
      an_next         = 2'b11;

      if ((state_reg == DIG0) || (state_reg == DIG1)) begin
         len_last = DWELL_LAST;
      end
      last = (cnt_reg == len_last);

      // The counter returns to zero on the same edge the state advances.
      if (last) begin
         cnt_next = '0;
         case (state_reg)
            BLANK1: begin
               state_next = DIG0;
               enter_dig0 = 1'b1;
            end
            DIG0: begin
               state_next   = BLANK0;
               enter_blank0 = 1'b1;
            end
            BLANK0: begin
               state_next = DIG1;
            end
            default: begin
               state_next   = BLANK1;
               enter_blank1 = 1'b1;
            end
         endcase
      end

      // Both latches capture the inputs present during the last DIG1 cycle.
      l0_next = enter_blank1 ? digit0_in : l0_reg;
      l1_next = enter_blank1 ? digit1_in : l1_reg;

      // The decoder input changes only on entry to a blank phase, so it has
      // a full blank phase to settle before its digit is enabled.
      nibble_next = nibble_reg;
      if (enter_blank1) begin
         nibble_next = l0_next;
      end else if (enter_blank0) begin
         nibble_next = l1_reg;
      end

      case (state_next)
         DIG0:    an_next = 2'b10;
         DIG1:    an_next = 2'b01;
         default: an_next = 2'b11;
      endcase

      frame_tick_next = enter_dig0;
   end

   // State and output registers; while in reset the latches track the inputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg      <= BLANK1;
         cnt_reg        <= '0;
         l0_reg         <= digit0_in;
         l1_reg         <= digit1_in;
         nibble_reg     <= digit0_in;
         an_reg         <= 2'b11;
         frame_tick_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         l0_reg         <= l0_next;
         l1_reg         <= l1_next;
         nibble_reg     <= nibble_next;
         an_reg         <= an_next;
         frame_tick_reg <= frame_tick_next;
      end
   end

   assign nibble     = nibble_reg;
   assign an         = an_reg;
   assign frame_tick = frame_tick_reg;

endmodule
